// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and common types,
// so the game logic can reference the visible-area limits.
package vga_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '0;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active-area and
// active-low sync window decodes of the current count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output logic   wrap,
  output logic   active,
  output logic   sync_n
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;

  if (TOTAL > COORD_MAX) begin : g_total_check
    $error("vga_axis_counter: TOTAL %0d does not fit in %0d bits", TOTAL, COORD_W);
  end

  coord_t              count_q;
  coord_t              count_d;
  logic                at_end;
  logic [COORD_W:0]    count_ext;

  always_comb begin
    at_end  = (count_q == coord_t'(TOTAL - 1));
    count_d = count_q;
    if (en) begin
      count_d = at_end ? '0 : count_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Window compares use one extra bit so a sync ending exactly at 1024 still decodes.
  assign count_ext = {1'b0, count_q};
  assign count     = count_q;
  assign wrap      = en & at_end;
  assign active    = (count_ext < (COORD_W+1)'(ACTIVE));
  assign sync_n    = ~((count_ext >= (COORD_W+1)'(SYNC_START)) &&
                       (count_ext <  (COORD_W+1)'(SYNC_END)));

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel/line counters for the game logic and a
// one-cycle output register that keeps colour and sync aligned.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic [3:0]         red_in,
  input  logic [3:0]         green_in,
  input  logic [3:0]         blue_in,
  output logic [COORD_W-1:0] h_coord,
  output logic [COORD_W-1:0] v_coord,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               display_on,
  output logic               frame_start
);

  logic h_wrap;
  logic h_active;
  logic h_sync_n;
  logic v_wrap_unused;
  logic v_active;
  logic v_sync_n;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk    (pixel_clk),
    .rst    (rst),
    .en     (1'b1),
    .count  (h_coord),
    .wrap   (h_wrap),
    .active (h_active),
    .sync_n (h_sync_n)
  );

  // The line counter only advances on the pixel counter's wrap cycle.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk    (pixel_clk),
    .rst    (rst),
    .en     (h_wrap),
    .count  (v_coord),
    .wrap   (v_wrap_unused),
    .active (v_active),
    .sync_n (v_sync_n)
  );

  assign display_on  = h_active & v_active;
  assign frame_start = (h_coord == '0) && (v_coord == '0);

  rgb_t pix_d;
  rgb_t pix_q;
  logic hs_d;
  logic hs_q;
  logic vs_d;
  logic vs_q;

  always_comb begin
    pix_d = RGB_BLACK;
    hs_d  = h_sync_n;
    vs_d  = v_sync_n;
    if (display_on) begin
      pix_d = {red_in, green_in, blue_in};
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      pix_q <= RGB_BLACK;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      pix_q <= pix_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign vga_r  = pix_q.r;
  assign vga_g  = pix_q.g;
  assign vga_b  = pix_q.b;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;

endmodule
